// File: rtl/clk_div_gate.sv
// Purpose: pulse-swallowing clock divider with glitch-free latch gate, idle auto-gating and scan override.
// Latency: clk_en_out registers one edge after the wrap; the matching clk_out pulse is the next clk high phase.
// Backpressure: none; busy only cancels auto-gating and div_update is acknowledged once with div_ack.
module clk_div_gate #(
  parameter int DIV_W     = 8,
  parameter int IDLE_W    = 6,
  parameter int RESET_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_ratio,
  input  logic              div_update,
  output logic              div_ack,
  input  logic              busy,
  input  logic [IDLE_W-1:0] idle_limit,
  input  logic              se,
  output logic              clk_out,
  output logic              clk_en_out,
  output logic              gated,
  output logic [DIV_W-1:0]  cur_ratio
);

  localparam logic [DIV_W-1:0]  RATIO_RST = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0]  ONE_D     = DIV_W'(1);
  localparam logic [IDLE_W-1:0] ONE_I     = IDLE_W'(1);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  cur_ratio_q, cur_ratio_d;
  logic [DIV_W-1:0]  pend_ratio_q, pend_ratio_d;
  logic              pending_q, pending_d;
  logic              clk_en_q, clk_en_d;
  logic              ack_q, ack_d;
  logic              gated_q, gated_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              gate_q;

  logic wrap;
  logic tick;
  logic apply;

  // Ratios of 0 and 1 both mean "every cycle", so they wrap unconditionally.
  assign wrap  = (cur_ratio_q <= ONE_D) || (cnt_q == (cur_ratio_q - ONE_D));
  assign tick  = wrap & en & ~gated_q;
  // A pending ratio lands on a period boundary, or straight away when the divider is stopped.
  assign apply = pending_q & (wrap | ~en);

  // Next-state logic for the divider, ratio update handshake and idle auto-gate.
  always_comb begin
    cnt_d        = cnt_q;
    cur_ratio_d  = cur_ratio_q;
    pend_ratio_d = pend_ratio_q;
    pending_d    = pending_q;
    clk_en_d     = tick;
    ack_d        = apply;
    gated_d      = gated_q;
    idle_cnt_d   = idle_cnt_q;

    if (!en || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE_D;
    end

    if (apply) begin
      cur_ratio_d = pend_ratio_q;
      pending_d   = 1'b0;
    end

    // A fresh request on the same edge as an apply re-arms for the following wrap.
    if (div_update) begin
      pend_ratio_d = (div_ratio == '0) ? ONE_D : div_ratio;
      pending_d    = 1'b1;
    end

    if (idle_limit == '0 || busy) begin
      idle_cnt_d = '0;
      gated_d    = 1'b0;
    end else if (wrap && en && !gated_q) begin
      idle_cnt_d = idle_cnt_q + ONE_I;
      // Compare against limit-1 so a lowered limit still gates on the next wrap.
      if (idle_cnt_q >= (idle_limit - ONE_I)) begin
        gated_d = 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q        <= '0;
      cur_ratio_q  <= RATIO_RST;
      pend_ratio_q <= RATIO_RST;
      pending_q    <= 1'b0;
      clk_en_q     <= 1'b0;
      ack_q        <= 1'b0;
      gated_q      <= 1'b0;
      idle_cnt_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      cur_ratio_q  <= cur_ratio_d;
      pend_ratio_q <= pend_ratio_d;
      pending_q    <= pending_d;
      clk_en_q     <= clk_en_d;
      ack_q        <= ack_d;
      gated_q      <= gated_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  // Gate enable latch: open only while clk is low so the enable is stable through each high phase.
  always_latch begin
    if (!rst_b) begin
      gate_q <= 1'b0;
    end else if (!clk) begin
      gate_q <= clk_en_q;
    end
  end

  assign clk_out    = clk & (gate_q | se);
  assign clk_en_out = clk_en_q;
  assign div_ack    = ack_q;
  assign gated      = gated_q;
  assign cur_ratio  = cur_ratio_q;

endmodule
